bool_equiv_checker: RTL and testbench
=====================================

// Module: bool_equiv_checker
// PURPOSE
//   Exhaustive equivalence checker for N_OUT pairs of N_IN-input boolean functions.
//   Each function is held as a 2^N_IN-bit truth table: set A is the original expression, set B the simplified one.
//   The block sweeps every input vector, one per clock, compares A[k] and B[k] for each k, and reports pass/fail.
//   It also reports the first failing vector and the count of mismatches.
//   This is the sequential, parametrised successor to the lab's fixed f/fb, g/gb, h/hb combinational comparisons.
// PARAMETERS
//   N_IN         6  number of function inputs; vector bit N_IN-1 is input A, ..., bit 0 is the last input
//   N_OUT        3  number of function pairs checked in parallel
//   STOP_ON_FAIL 1  1: end sweep at the first mismatching vector; 0: sweep all vectors and count mismatches
// PORTS
//   clk          in   1          rising-edge clock
//   rst_n        in   1          asynchronous active-low reset
//   cfg_valid    in   1          truth-table write request
//   cfg_ready    out  1          write accepted on the edge where cfg_valid&&cfg_ready
//   cfg_set      in   1          0 selects set A, 1 selects set B
//   cfg_fn       in   clog2(N_OUT) function index; write ignored if >= N_OUT
//   cfg_data     in   2^N_IN     full truth table; bit v = f(vector v)
//   start        in   1          one-cycle pulse; begins a sweep when state is IDLE or DONE
//   abort        in   1          returns to IDLE from any state; results are cleared
//   busy         out  1          high in SWEEP
//   done         out  1          high in DONE, held until start or abort
//   pass         out  1          valid while done: 1 if no mismatch was found
//   fail_vec     out  N_IN       first mismatching vector; 0 if none
//   fail_mask    out  N_OUT      mismatching outputs at fail_vec; bit k means A[k]!=B[k]
//   mismatch_cnt out  N_IN+1     number of vectors with any mismatch; saturates at 2^N_IN
// BEHAVIOUR
//   Reset: state=IDLE; all tables=0; vec=0.
//   Reset outputs: cfg_ready=1, busy=0, done=0, pass=0, fail_vec=0, fail_mask=0, mismatch_cnt=0.
//   Reset is async assert, sync release. Reset mid-sweep discards all results and tables.
//   cfg_ready=1 in IDLE and DONE and 0 in SWEEP; writes during SWEEP stall.
//   An accepted write updates the table on the same edge.
//   A write while in DONE leaves the results intact.
//   FSM IDLE->SWEEP: on start. On the same edge: vec=0, mismatch_cnt=0, fail_vec=0, fail_mask=0, pass=0, done=0.
//   FSM DONE->SWEEP: on start, with the same clearing as IDLE->SWEEP.
//   SWEEP, each cycle: m[k] = A[k][vec] ^ B[k][vec] for all k, combinational from registered vec.
//     On each edge: if |m is set and this is the first mismatch, capture fail_vec=vec and fail_mask=m.
//     If |m is set, mismatch_cnt increments.
//     Then vec increments.
//   SWEEP->DONE, STOP_ON_FAIL=1: on the first mismatch edge, so that edge is 1+v edges after start (v = failing vector).
//   SWEEP->DONE, otherwise: on the edge that evaluates vec=2^N_IN-1, i.e. 2^N_IN edges after start.
//   The vec counter never wraps into a second pass.
//   In DONE: pass = (mismatch_cnt==0). done, pass and fail_* hold.
//   start in SWEEP is ignored.
//   abort has priority over start and cfg on the same edge. abort -> IDLE with outputs at reset values; tables are kept.
//   start and a cfg write on the same edge in IDLE or DONE: the write lands, and the sweep uses the new table from vector 0.
// TESTING
//   T1, N_IN=6: load A=B for k=0..2 with 64'hF0F0_1234_DEAD_BEEF patterns, start
//     -> done after 64 edges, pass=1, mismatch_cnt=0.
//   T2: flip bit 37 of B[1], STOP_ON_FAIL=1, start
//     -> done at edge 38, pass=0, fail_vec=37, fail_mask=3'b010, mismatch_cnt=1.
//   T3: STOP_ON_FAIL=0, flip bit 5 of B[0] and B[2] and bit 60 of B[2]
//     -> at edge 64: fail_vec=5, fail_mask=3'b101, mismatch_cnt=2.
//   T4: cfg_valid during SWEEP -> cfg_ready=0 until DONE; the write lands on the first DONE cycle and results are unchanged.
//   T5: abort at edge 20 of a sweep -> IDLE, busy=0, done=0; the next start resweeps from vec 0 with the tables intact.
//   T6: rst_n low mid-sweep -> all outputs go to reset values immediately; after release a sweep of zero tables gives pass=1.

Source files
------------

// File: rtl/bool_equiv_checker.sv
// Exhaustive equivalence checker: sweeps every input vector once and compares
// N_OUT pairs of truth tables (set A original, set B simplified).
//
// state   | meaning
// S_IDLE  | waiting for start; results at reset values; tables writable
// S_SWEEP | evaluating one vector per clock; cfg writes stall
// S_DONE  | results held until start or abort; tables writable
module bool_equiv_checker #(
    parameter int N_IN         = 6,
    parameter int N_OUT        = 3,
    parameter int STOP_ON_FAIL = 1,
    localparam int TW          = 1 << N_IN,
    localparam int FN_W        = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_set,
    input  logic [FN_W-1:0]   cfg_fn,
    input  logic [TW-1:0]     cfg_data,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN-1:0]   fail_vec,
    output logic [N_OUT-1:0]  fail_mask,
    output logic [N_IN:0]     mismatch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [N_IN:0] CNT_MAX = (N_IN + 1)'(TW);

    state_t            r_state;
    state_t            w_next;
    logic [TW-1:0]     r_tab_a [N_OUT];
    logic [TW-1:0]     r_tab_b [N_OUT];
    logic [N_IN-1:0]   r_vec;
    logic [N_IN:0]     r_cnt;
    logic [N_IN-1:0]   r_fail_vec;
    logic [N_OUT-1:0]  r_fail_mask;

    logic [N_OUT-1:0]  w_m;
    logic              w_any;
    logic              w_last;
    logic              w_clear;
    logic              w_cfg_acc;

    always_comb begin
        w_m = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_m[k] = r_tab_a[k][r_vec] ^ r_tab_b[k][r_vec];
        end
    end

    assign w_any     = |w_m;
    assign w_last    = (r_vec == {N_IN{1'b1}});
    assign w_clear   = abort || (start && (r_state != S_SWEEP));
    assign w_cfg_acc = cfg_valid && cfg_ready && !abort && (int'(cfg_fn) < N_OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_SWEEP;
            end
            S_SWEEP: begin
                if ((w_any && (STOP_ON_FAIL != 0)) || w_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (start) w_next = S_SWEEP;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    // Tables survive abort; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                r_tab_a[k] <= '0;
                r_tab_b[k] <= '0;
            end
        end else if (w_cfg_acc) begin
            if (cfg_set) r_tab_b[cfg_fn] <= cfg_data;
            else         r_tab_a[cfg_fn] <= cfg_data;
        end
    end

    // A zero count means no mismatch has been seen yet, so it doubles as the
    // first-failure qualifier for the capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec       <= '0;
            r_cnt       <= '0;
            r_fail_vec  <= '0;
            r_fail_mask <= '0;
        end else if (w_clear) begin
            r_vec       <= '0;
            r_cnt       <= '0;
            r_fail_vec  <= '0;
            r_fail_mask <= '0;
        end else if (r_state == S_SWEEP) begin
            if (w_any) begin
                if (r_cnt == '0) begin
                    r_fail_vec  <= r_vec;
                    r_fail_mask <= w_m;
                end
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            end
            if (!w_last) r_vec <= r_vec + 1'b1;
        end
    end

    assign cfg_ready    = (r_state != S_SWEEP);
    assign busy         = (r_state == S_SWEEP);
    assign done         = (r_state == S_DONE);
    assign pass         = (r_state == S_DONE) && (r_cnt == '0);
    assign fail_vec     = r_fail_vec;
    assign fail_mask    = r_fail_mask;
    assign mismatch_cnt = r_cnt;

endmodule

// File: tb/tb_bool_equiv_checker.sv
// Bench for bool_equiv_checker: two instances (stop-on-fail and full sweep)
// share stimulus; directed table, corner sequences and randomized tables.
module tb_bool_equiv_checker;

    localparam int N_IN  = 6;
    localparam int N_OUT = 3;
    localparam int TW    = 1 << N_IN;

    typedef logic [N_OUT-1:0][TW-1:0] tabs_t;

    typedef struct {
        tabs_t             a;
        tabs_t             b;
        int                edges1;
        logic [N_IN-1:0]   fvec;
        logic [N_OUT-1:0]  fmask;
        int                cnt1;
        int                cnt0;
    } tv_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid, cfg_set, start, abort;
    logic [1:0]        cfg_fn;
    logic [TW-1:0]     cfg_data;
    logic              rdy1, busy1, done1, pass1, rdy0, busy0, done0, pass0;
    logic [N_IN-1:0]   fvec1, fvec0;
    logic [N_OUT-1:0]  fmask1, fmask0;
    logic [N_IN:0]     cnt1, cnt0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bool_equiv_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .STOP_ON_FAIL(1)) u_sof1 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(rdy1),
        .cfg_set(cfg_set), .cfg_fn(cfg_fn), .cfg_data(cfg_data),
        .start(start), .abort(abort), .busy(busy1), .done(done1), .pass(pass1),
        .fail_vec(fvec1), .fail_mask(fmask1), .mismatch_cnt(cnt1)
    );

    bool_equiv_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .STOP_ON_FAIL(0)) u_sof0 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(rdy0),
        .cfg_set(cfg_set), .cfg_fn(cfg_fn), .cfg_data(cfg_data),
        .start(start), .abort(abort), .busy(busy0), .done(done0), .pass(pass0),
        .fail_vec(fvec0), .fail_mask(fmask0), .mismatch_cnt(cnt0)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic write_tab(input bit set, input int fn, input logic [TW-1:0] data);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_set   = set;
        cfg_fn    = 2'(fn);
        cfg_data  = data;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic load(input tabs_t a, input tabs_t b);
        for (int k = 0; k < N_OUT; k++) begin
            write_tab(1'b0, k, a[k]);
            write_tab(1'b1, k, b[k]);
        end
    endtask

    // Start edge is edge 0; e1/e0 are the edge numbers on which done rose.
    task automatic run_sweep(input bit wr, input logic [TW-1:0] wdata,
                             output int e1, output int e0);
        @(negedge clk);
        start = 1'b1;
        if (wr) begin
            cfg_valid = 1'b1; cfg_set = 1'b1; cfg_fn = 2'd2; cfg_data = wdata;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_valid = 1'b0;
        chk("busy_after_start", busy0, 1);
        e1 = -1;
        e0 = -1;
        for (int n = 1; n <= 100 && (e1 < 0 || e0 < 0); n++) begin
            @(posedge clk);
            #1;
            if (done1 && e1 < 0) e1 = n;
            if (done0 && e0 < 0) e0 = n;
        end
    endtask

    task automatic check_results(input string tag, input int e1, input int e0,
                                 input int x_edges1, input logic [N_IN-1:0] x_fvec,
                                 input logic [N_OUT-1:0] x_fmask, input int x_cnt1,
                                 input int x_cnt0);
        chk({tag, "_edges_sof1"}, e1, x_edges1);
        chk({tag, "_edges_sof0"}, e0, TW);
        chk({tag, "_pass_sof1"}, pass1, (x_cnt1 == 0));
        chk({tag, "_pass_sof0"}, pass0, (x_cnt0 == 0));
        chk({tag, "_fvec_sof1"}, fvec1, x_fvec);
        chk({tag, "_fvec_sof0"}, fvec0, x_fvec);
        chk({tag, "_fmask_sof1"}, fmask1, x_fmask);
        chk({tag, "_fmask_sof0"}, fmask0, x_fmask);
        chk({tag, "_cnt_sof1"}, cnt1, x_cnt1);
        chk({tag, "_cnt_sof0"}, cnt0, x_cnt0);
    endtask

    // Reference: walk every vector, bit-compare the tables.
    function automatic void model(input tabs_t a, input tabs_t b, output int first,
                                  output logic [N_OUT-1:0] mask, output int cnt);
        first = -1;
        mask  = '0;
        cnt   = 0;
        for (int v = 0; v < TW; v++) begin
            logic [N_OUT-1:0] m;
            for (int k = 0; k < N_OUT; k++) m[k] = a[k][v] != b[k][v];
            if (m != 0) begin
                cnt++;
                if (first < 0) begin
                    first = v;
                    mask  = m;
                end
            end
        end
    endfunction

    initial begin
        logic [TW-1:0] p, q, r;
        tabs_t base, tb2;
        tv_t tv[5];
        int e1, e0, acc1, acc0, rdy_err;
        bit s1, s0;

        p = 64'hF0F0_1234_DEAD_BEEF;
        q = ~p;
        r = {p[31:0], p[63:32]};
        base = {r, q, p};
        for (int i = 0; i < 5; i++) begin
            tv[i].a = base;
            tv[i].b = base;
        end
        tv[0].edges1 = 64; tv[0].fvec = 0;  tv[0].fmask = 3'b000; tv[0].cnt1 = 0; tv[0].cnt0 = 0;
        tv[1].b[1] ^= 64'd1 << 37;
        tv[1].edges1 = 38; tv[1].fvec = 37; tv[1].fmask = 3'b010; tv[1].cnt1 = 1; tv[1].cnt0 = 1;
        tv[2].b[0] ^= 64'd1 << 5;
        tv[2].b[2] ^= (64'd1 << 5) | (64'd1 << 60);
        tv[2].edges1 = 6;  tv[2].fvec = 5;  tv[2].fmask = 3'b101; tv[2].cnt1 = 1; tv[2].cnt0 = 2;
        tv[3].b[2] ^= 64'd1 << 63;
        tv[3].edges1 = 64; tv[3].fvec = 63; tv[3].fmask = 3'b100; tv[3].cnt1 = 1; tv[3].cnt0 = 1;
        tv[4].b = ~base;
        tv[4].edges1 = 1;  tv[4].fvec = 0;  tv[4].fmask = 3'b111; tv[4].cnt1 = 1; tv[4].cnt0 = 64;

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_set = 1'b0; cfg_fn = '0; cfg_data = '0;
        start = 1'b0; abort = 1'b0;
        #12;
        chk("rst_ready", rdy1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_fvec", fvec1, 0);
        chk("rst_fmask", fmask1, 0);
        chk("rst_cnt", cnt0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            load(tv[i].a, tv[i].b);
            run_sweep(1'b0, '0, e1, e0);
            check_results($sformatf("tv%0d", i), e1, e0, tv[i].edges1, tv[i].fvec,
                          tv[i].fmask, tv[i].cnt1, tv[i].cnt0);
        end

        // Write held through a sweep lands on the first DONE cycle; results stay.
        load(tv[1].a, tv[1].b);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_set = 1'b1; cfg_fn = 2'd1; cfg_data = tv[1].a[1];
        acc1 = -1; acc0 = -1; rdy_err = 0;
        for (int n = 1; n <= 100 && (acc1 < 0 || acc0 < 0); n++) begin
            s1 = rdy1;
            s0 = rdy0;
            if (rdy1 == busy1 || rdy0 == busy0) rdy_err++;
            @(posedge clk);
            if (s1 && acc1 < 0) acc1 = n;
            if (s0 && acc0 < 0) acc0 = n;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        chk("stall_ready_vs_busy", rdy_err, 0);
        chk("stall_accept_sof1", acc1, 39);
        chk("stall_accept_sof0", acc0, 65);
        chk("stall_done_sof1", done1, 1);
        chk("stall_fvec_sof1", fvec1, 37);
        chk("stall_fmask_sof1", fmask1, 3'b010);
        chk("stall_cnt_sof0", cnt0, 1);
        run_sweep(1'b0, '0, e1, e0);
        check_results("stall_resweep", e1, e0, 64, 0, 0, 0, 0);

        // Abort at edge 20 clears results; tables kept for the next sweep.
        load(tv[2].a, tv[2].b);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("abort_pre_cnt_sof0", cnt0, 1);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_done_sof0", done0, 0);
        chk("abort_done_sof1", done1, 0);
        chk("abort_cnt_sof0", cnt0, 0);
        chk("abort_fvec_sof1", fvec1, 0);
        chk("abort_fmask_sof1", fmask1, 0);
        chk("abort_ready", rdy0, 1);
        run_sweep(1'b0, '0, e1, e0);
        check_results("abort_resweep", e1, e0, tv[2].edges1, tv[2].fvec, tv[2].fmask,
                      tv[2].cnt1, tv[2].cnt0);

        // Reset mid-sweep is immediate and wipes the tables.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done1, 0);
        chk("midrst_cnt", cnt0, 0);
        chk("midrst_fvec", fvec1, 0);
        chk("midrst_fmask", fmask1, 0);
        chk("midrst_ready", rdy0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(1'b0, '0, e1, e0);
        check_results("midrst_zero", e1, e0, 64, 0, 0, 0, 0);

        // Random tables with sparse flips; odd runs write B[2] with the start pulse.
        for (int it = 0; it < 12; it++) begin
            tabs_t ra, rb;
            int first, cnt;
            logic [N_OUT-1:0] mask;
            for (int k = 0; k < N_OUT; k++) begin
                ra[k] = {$urandom, $urandom};
                if ($urandom_range(3) == 0) rb[k] = ra[k];
                else rb[k] = ra[k] ^ ({$urandom, $urandom} & {$urandom, $urandom}
                                    & {$urandom, $urandom} & {$urandom, $urandom});
            end
            model(ra, rb, first, mask, cnt);
            tb2 = rb;
            if (it % 2 == 1) tb2[2] = ~rb[2];
            load(ra, tb2);
            run_sweep(it % 2 == 1, rb[2], e1, e0);
            check_results($sformatf("rnd%0d", it), e1, e0,
                          (first >= 0) ? first + 1 : TW,
                          (first >= 0) ? N_IN'(first) : '0, mask,
                          (first >= 0) ? 1 : 0, cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
